// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions: field layout, special encodings and the
// piecewise-linear ln(1.m) tables used by the natural-log unit.
package bf16_pkg;

  localparam int BF16_W   = 16;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 7;
  localparam int SIGN_POS = 15;
  localparam int EXP_LSB  = 7;
  localparam int BIAS     = 127;
  localparam int FRAC_W   = 16;
  localparam int SUM_W    = 25;

  localparam logic [BF16_W-1:0] BF16_POS_INF = 16'h7F80;
  localparam logic [BF16_W-1:0] BF16_NEG_INF = 16'hFF80;
  localparam logic [BF16_W-1:0] BF16_QNAN    = 16'h7FC0;

  localparam logic [FRAC_W-1:0] LN2_Q16 = 16'd45426;

  // Segment k covers mantissa 1 + k/8 .. 1 + (k+1)/8; slope is per 1/128 step.
  localparam logic [FRAC_W-1:0] LN_BASE [8] = '{
    16'd0, 16'd7719, 16'd14624, 16'd20870,
    16'd26573, 16'd31818, 16'd36675, 16'd41196
  };
  localparam logic [8:0] LN_SLOPE [8] = '{
    9'd482, 9'd432, 9'd390, 9'd356, 9'd328, 9'd304, 9'd283, 9'd264
  };

endpackage

// File: rtl/bf16_norm_round.sv
// Converts a signed Q8.16 fixed-point value to bfloat16 with round-to-nearest-even.
module bf16_norm_round
  import bf16_pkg::*;
(
  input  logic signed [SUM_W-1:0]  sum_i,
  output logic        [BF16_W-1:0] data_o
);

  logic [23:0]      mag;
  logic [4:0]       lead;
  logic [23:0]      norm;
  logic [MAN_W-1:0] mant;
  logic             guard;
  logic             sticky;
  logic             roundUp;
  logic [MAN_W:0]   mantRnd;
  logic [EXP_W-1:0] expo;

  // Magnitude never reaches 2^24, so the leading one sits at bit 23 or below.
  always_comb begin
    mag = sum_i[SUM_W-1] ? 24'(-sum_i) : 24'(sum_i);
    lead = '0;
    for (int i = 0; i < 24; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    norm    = mag << (5'd23 - lead);
    mant    = norm[22:16];
    guard   = norm[15];
    sticky  = |norm[14:0];
    roundUp = guard & (sticky | mant[0]);
    mantRnd = {1'b0, mant} + {{MAN_W{1'b0}}, roundUp};
    expo    = 8'd111 + {3'b000, lead} + {7'd0, mantRnd[MAN_W]};
    if (sum_i == '0) begin
      data_o = '0;
    end else begin
      data_o = {sum_i[SUM_W-1], expo, mantRnd[MAN_W-1:0]};
    end
  end

endmodule

// File: rtl/bf16_ln.sv
// Three-stage bfloat16 natural-log unit: classify/lookup, fixed-point sum,
// normalise/round. One global advance enable stalls the whole pipeline.
module bf16_ln
  import bf16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BF16_W-1:0] data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BF16_W-1:0] data_o
);

  logic                    en;
  logic                    inSign;
  logic [EXP_W-1:0]        inExp;
  logic [MAN_W-1:0]        inMan;

  logic                    special1_d;
  logic [BF16_W-1:0]       forced1_d;
  logic                    valid1_q;
  logic                    special1_q;
  logic [BF16_W-1:0]       forced1_q;
  logic [EXP_W-1:0]        exp1_q;
  logic [2:0]              seg1_q;
  logic [3:0]              off1_q;

  logic [FRAC_W:0]         frac;
  logic signed [8:0]       expUnb;
  logic signed [SUM_W-1:0] sum2_d;
  logic                    valid2_q;
  logic                    special2_q;
  logic [BF16_W-1:0]       forced2_q;
  logic signed [SUM_W-1:0] sum2_q;

  logic [BF16_W-1:0]       normData;
  logic                    outValid_q;
  logic [BF16_W-1:0]       dataOut_q;

  assign inSign    = data_i[SIGN_POS];
  assign inExp     = data_i[EXP_LSB +: EXP_W];
  assign inMan     = data_i[MAN_W-1:0];
  assign en        = !outValid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = outValid_q;
  assign data_o    = dataOut_q;

  // Denormals flush to zero, so e==0 is checked before the sign.
  always_comb begin
    special1_d = 1'b1;
    forced1_d  = BF16_QNAN;
    if (inExp == '0) begin
      forced1_d = BF16_NEG_INF;
    end else if (inSign) begin
      forced1_d = BF16_QNAN;
    end else if (inExp == '1) begin
      forced1_d = (inMan != '0) ? BF16_QNAN : BF16_POS_INF;
    end else begin
      special1_d = 1'b0;
    end
  end

  always_comb begin
    frac   = 17'(LN_BASE[seg1_q]) + 17'(13'(LN_SLOPE[seg1_q]) * 13'(off1_q));
    expUnb = 9'($signed({1'b0, exp1_q}) - BIAS);
    sum2_d = $signed({{16{expUnb[8]}}, expUnb}) * $signed({9'd0, LN2_Q16})
           + $signed({8'd0, frac});
  end

  bf16_norm_round u_norm_round (
    .sum_i  (sum2_q),
    .data_o (normData)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid1_q   <= 1'b0;
      special1_q <= 1'b0;
      forced1_q  <= '0;
      exp1_q     <= '0;
      seg1_q     <= '0;
      off1_q     <= '0;
      valid2_q   <= 1'b0;
      special2_q <= 1'b0;
      forced2_q  <= '0;
      sum2_q     <= '0;
      outValid_q <= 1'b0;
      dataOut_q  <= '0;
    end else if (en) begin
      valid1_q <= in_valid;
      if (in_valid) begin
        special1_q <= special1_d;
        forced1_q  <= forced1_d;
        exp1_q     <= inExp;
        seg1_q     <= inMan[6:4];
        off1_q     <= inMan[3:0];
      end
      valid2_q <= valid1_q;
      if (valid1_q) begin
        special2_q <= special1_q;
        forced2_q  <= forced1_q;
        sum2_q     <= sum2_d;
      end
      outValid_q <= valid2_q;
      if (valid2_q) begin
        dataOut_q <= special2_q ? forced2_q : normData;
      end
    end
  end

endmodule

// File: tb/tb_bf16_ln.sv
// Self-checking bench for bf16_ln: directed values, specials, streaming,
// backpressure, reset mid-flight and a randomised sweep against a reference.
module tb_bf16_ln;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] data_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] data_o;

  int checks   = 0;
  int failures = 0;
  int cycleNo  = 0;

  logic [15:0] sbExp [$];
  logic [15:0] sbIn  [$];
  int          sbCyc [$];

  localparam int LN_BASE_TB [8]  = '{0, 7719, 14624, 20870, 26573, 31818, 36675, 41196};
  localparam int LN_SLOPE_TB [8] = '{482, 432, 390, 356, 328, 304, 283, 264};

  localparam int NDIR = 15;
  localparam logic [15:0] DIR_IN [NDIR] = '{
    16'h3F80, 16'h4000, 16'h3F00, 16'h402E, 16'h3F81, 16'h3F7F, 16'h7F7F, 16'h0080,
    16'h0000, 16'h0001, 16'hBF80, 16'h7F80, 16'h7FC1, 16'hFFFF, 16'h8000
  };
  localparam logic [15:0] DIR_EXP [NDIR] = '{
    16'h0000, 16'h3F31, 16'hBF31, 16'h3F80, 16'h3BF1, 16'hBB87, 16'h42B1, 16'hC2AF,
    16'hFF80, 16'hFF80, 16'h7FC0, 16'h7F80, 16'h7FC0, 16'h7FC0, 16'hFF80
  };

  bf16_ln dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_i    (data_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_o    (data_o)
  );

  always #5 clk = ~clk;

  // Reference: fixed-point sum, then rounding done on the IEEE double encoding.
  function automatic logic [15:0] refLn(input logic [15:0] x);
    int          e, m, k, f, sum, de;
    real         r;
    logic [63:0] b;
    logic        up;
    logic [7:0]  tr;
    e = int'(x[14:7]);
    m = int'(x[6:0]);
    if (e == 0) return 16'hFF80;
    if (x[15]) return 16'h7FC0;
    if (e == 255) return (m != 0) ? 16'h7FC0 : 16'h7F80;
    k   = m / 16;
    f   = m % 16;
    sum = (e - 127) * 45426 + LN_BASE_TB[k] + LN_SLOPE_TB[k] * f;
    if (sum == 0) return 16'h0000;
    r  = real'(sum) / 65536.0;
    b  = $realtobits(r);
    up = b[44] & ((|b[43:0]) | b[45]);
    tr = {1'b0, b[51:45]} + {7'd0, up};
    de = int'(b[62:52]) - 1023 + 127 + int'(tr[7]);
    return {b[63], 8'(de), tr[6:0]};
  endfunction

  function automatic real bf16ToReal(input logic [15:0] x);
    real v;
    if (x[14:7] == 8'd0) return 0.0;
    v = $pow(2.0, real'(int'(x[14:7]) - 127)) * (1.0 + real'(int'(x[6:0])) / 128.0);
    return x[15] ? -v : v;
  endfunction

  // One clock of stimulus; samples handshake and output mid-cycle, before the edge.
  task automatic applyStimulus(input logic v, input logic [15:0] d, input logic r,
                               output logic acc, output logic fire, output logic [15:0] obs);
    in_valid  = v;
    data_i    = d;
    out_ready = r;
    #1;
    acc  = v & in_ready;
    fire = out_valid & out_ready;
    obs  = data_o;
    @(posedge clk);
    @(negedge clk);
    cycleNo++;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; data_i = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b required=0", out_valid); end
    checks++;
    if (data_o !== 16'h0000) begin failures++; $display("[TB] FAIL reset_data_o got=%h required=0000", data_o); end
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready got=%b required=1", in_ready); end
  endtask

  task automatic test_values();
    int idx = 0, budget = 0, c, ac;
    logic v, acc, fire;
    logic [15:0] obs, ex, xi;
    while ((idx < NDIR || sbExp.size() > 0) && budget < 200) begin
      v = (idx < NDIR) && ($urandom_range(0, 3) != 0);
      c = cycleNo;
      applyStimulus(v, v ? DIR_IN[idx] : 16'h0000, 1'b1, acc, fire, obs);
      if (fire) begin
        checks++;
        if (sbExp.size() == 0) begin
          failures++; $display("[TB] FAIL values_extra got=%h required=no output", obs);
        end else begin
          ex = sbExp.pop_front(); xi = sbIn.pop_front(); ac = sbCyc.pop_front();
          if (obs !== ex) begin failures++; $display("[TB] FAIL values_data in=%h got=%h required=%h", xi, obs, ex); end
          checks++;
          if (c - ac != 3) begin failures++; $display("[TB] FAIL values_latency in=%h got=%0d required=3", xi, c - ac); end
          checks++;
          if (refLn(xi) !== ex) begin failures++; $display("[TB] FAIL values_model in=%h got=%h required=%h", xi, refLn(xi), ex); end
        end
      end
      if (acc) begin
        sbExp.push_back(DIR_EXP[idx]); sbIn.push_back(DIR_IN[idx]); sbCyc.push_back(c); idx++;
      end
      budget++;
    end
    checks++;
    if (sbExp.size() != 0 || idx != NDIR) begin
      failures++; $display("[TB] FAIL values_drain got=%0d pending required=0", sbExp.size() + NDIR - idx);
      sbExp.delete(); sbIn.delete(); sbCyc.delete();
    end
  endtask

  task automatic test_back_to_back();
    int sent = 0, accepted = 0, budget = 0, c, ac;
    logic v, acc, fire;
    logic [15:0] obs, ex, xi, x;
    while ((sent < 12 || sbExp.size() > 0) && budget < 40) begin
      v = (sent < 12);
      x = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
      c = cycleNo;
      applyStimulus(v, x, 1'b1, acc, fire, obs);
      if (fire) begin
        checks++;
        if (sbExp.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_extra got=%h required=no output", obs);
        end else begin
          ex = sbExp.pop_front(); xi = sbIn.pop_front(); ac = sbCyc.pop_front();
          if (obs !== ex) begin failures++; $display("[TB] FAIL b2b_data in=%h got=%h required=%h", xi, obs, ex); end
          checks++;
          if (c - ac != 3) begin failures++; $display("[TB] FAIL b2b_latency in=%h got=%0d required=3", xi, c - ac); end
        end
      end
      if (v) sent++;
      if (acc) begin
        accepted++; sbExp.push_back(refLn(x)); sbIn.push_back(x); sbCyc.push_back(c);
      end
      budget++;
    end
    checks++;
    if (accepted != 12) begin failures++; $display("[TB] FAIL b2b_accepted got=%0d required=12", accepted); end
    checks++;
    if (sbExp.size() != 0) begin
      failures++; $display("[TB] FAIL b2b_drain got=%0d pending required=0", sbExp.size());
      sbExp.delete(); sbIn.delete(); sbCyc.delete();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] srcIn [4]  = '{16'h3F80, 16'h4000, 16'h3F00, 16'h3F81};
    logic [15:0] srcExp [4] = '{16'h0000, 16'h3F31, 16'hBF31, 16'h3BF1};
    int idx = 0, budget = 0;
    logic v, r, acc, fire;
    logic [15:0] obs, ex, xi, held;
    held = 16'h0000;
    while ((idx < 4 || sbExp.size() > 0) && budget < 40) begin
      v = (idx < 4) && (budget != 3);
      r = !(budget >= 4 && budget <= 8);
      applyStimulus(v, v ? srcIn[idx] : 16'h0000, r, acc, fire, obs);
      if (!r) begin
        checks++;
        if (acc || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_in_ready cycle=%0d got=%b required=0", budget, in_ready); end
        checks++;
        if (out_valid !== 1'b1 || sbExp.size() == 0 || obs !== sbExp[0]) begin
          failures++; $display("[TB] FAIL bp_hold cycle=%0d got=%h valid=%b required=%h", budget, obs, out_valid, (sbExp.size() > 0) ? sbExp[0] : 16'hxxxx);
        end
        if (budget == 4) held = obs;
        checks++;
        if (obs !== held) begin failures++; $display("[TB] FAIL bp_stable cycle=%0d got=%h required=%h", budget, obs, held); end
      end
      if (fire) begin
        checks++;
        if (sbExp.size() == 0) begin
          failures++; $display("[TB] FAIL bp_extra got=%h required=no output", obs);
        end else begin
          ex = sbExp.pop_front(); xi = sbIn.pop_front(); void'(sbCyc.pop_front());
          if (obs !== ex) begin failures++; $display("[TB] FAIL bp_data in=%h got=%h required=%h", xi, obs, ex); end
        end
      end
      if (acc) begin
        sbExp.push_back(srcExp[idx]); sbIn.push_back(srcIn[idx]); sbCyc.push_back(cycleNo - 1); idx++;
      end
      budget++;
    end
    checks++;
    if (sbExp.size() != 0 || idx != 4) begin
      failures++; $display("[TB] FAIL bp_drain got=%0d pending required=0", sbExp.size() + 4 - idx);
      sbExp.delete(); sbIn.delete(); sbCyc.delete();
    end
  endtask

  task automatic test_reset_midflight();
    int fires = 0, budget = 0, c, ac;
    logic acc, fire, got;
    logic [15:0] obs;
    applyStimulus(1'b1, 16'h4000, 1'b1, acc, fire, obs);
    applyStimulus(1'b1, 16'h3F00, 1'b1, acc, fire, obs);
    applyStimulus(1'b0, 16'h0000, 1'b0, acc, fire, obs);
    rst = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_valid got=%b required=0", out_valid); end
    checks++;
    if (data_o !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mid_data got=%h required=0000", data_o); end
    sbExp.delete(); sbIn.delete(); sbCyc.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      applyStimulus(1'b0, 16'h0000, 1'b1, acc, fire, obs);
      if (out_valid === 1'b1) fires++;
    end
    checks++;
    if (fires != 0) begin failures++; $display("[TB] FAIL rst_mid_ghost got=%0d outputs required=0", fires); end
    ac = cycleNo;
    applyStimulus(1'b1, 16'h3F80, 1'b1, acc, fire, obs);
    got = 1'b0;
    while (!got && budget < 10) begin
      c = cycleNo;
      applyStimulus(1'b0, 16'h0000, 1'b1, acc, fire, obs);
      if (fire) begin
        got = 1'b1;
        checks++;
        if (obs !== 16'h0000) begin failures++; $display("[TB] FAIL rst_mid_data_after got=%h required=0000", obs); end
        checks++;
        if (c - ac != 3) begin failures++; $display("[TB] FAIL rst_mid_latency got=%0d required=3", c - ac); end
      end
      budget++;
    end
    checks++;
    if (!got) begin failures++; $display("[TB] FAIL rst_mid_timeout got=no output required=1 output"); end
  endtask

  task automatic test_sweep();
    int sent = 0, budget = 0;
    logic v, r, acc, fire, have;
    logic [15:0] obs, ex, xi, x;
    real err, tol, ulp;
    have = 1'b0;
    x = 16'h0000;
    while ((sent < 400 || sbExp.size() > 0) && budget < 4000) begin
      if (!have && sent < 400) begin
        if ($urandom_range(0, 9) == 0) x = 16'($urandom);
        else x = {1'b0, 8'($urandom_range(1, 254)), 7'($urandom)};
        have = 1'b1;
      end
      v = have && ($urandom_range(0, 4) != 0);
      r = ($urandom_range(0, 3) != 0);
      applyStimulus(v, x, r, acc, fire, obs);
      if (fire) begin
        checks++;
        if (sbExp.size() == 0) begin
          failures++; $display("[TB] FAIL sweep_extra got=%h required=no output", obs);
        end else begin
          ex = sbExp.pop_front(); xi = sbIn.pop_front(); void'(sbCyc.pop_front());
          if (obs !== ex) begin failures++; $display("[TB] FAIL sweep_data in=%h got=%h required=%h", xi, obs, ex); end
          if (!xi[15] && xi[14:7] != 8'd0 && xi[14:7] != 8'hFF) begin
            ulp = $pow(2.0, real'(int'(obs[14:7]) - 134));
            tol = $pow(2.0, -8.0) + 2.0 * ulp;
            err = bf16ToReal(obs) - $ln(bf16ToReal(xi));
            if (err < 0.0) err = -err;
            checks++;
            if (err > tol) begin failures++; $display("[TB] FAIL sweep_accuracy in=%h got=%h error=%f allowed=%f", xi, obs, err, tol); end
          end
        end
      end
      if (acc) begin
        sbExp.push_back(refLn(x)); sbIn.push_back(x); sbCyc.push_back(cycleNo - 1);
        sent++; have = 1'b0;
      end
      budget++;
    end
    checks++;
    if (sbExp.size() != 0 || sent != 400) begin
      failures++; $display("[TB] FAIL sweep_drain got=%0d pending required=0", sbExp.size() + 400 - sent);
      sbExp.delete(); sbIn.delete(); sbCyc.delete();
    end
  endtask

  initial begin
    test_reset();
    test_values();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    test_sweep();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got=timeout required=completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
